adder_result_checker: RTL and testbench
=======================================

# adder_result_checker

Self-checking response block for the 32-bit ripple adder. It consumes one transaction per handshake: operands a/b/cin plus the adder's z/cout. It computes the full-width reference sum {cout, z} = a + b + cin, compares all WIDTH+1 bits so carry-out is never silently dropped, and maintains pass/fail counters. It also captures the first failing transaction and can optionally halt intake on the first failure. It sits on the far side of the adder, opposite the stimulus driver, in both simulation benches and on-chip self-test.

## Interface
- WIDTH, 32, operand/sum width
- CNT_W, 16, width of pass/fail counters
- HALT_ON_FAIL, 0, 1 = stop accepting transactions after the first mismatch until clear
- clk  input  1  rising-edge clock, only clock
- rst_n  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- clear  input  1  synchronous soft clear; same effect as reset on all state
- in_valid  input  1  transaction present
- in_ready  output  1  checker can accept; transfer when in_valid && in_ready
- a, b  input  WIDTH  adder operands
- cin  input  1  adder carry-in
- z  input  WIDTH  adder sum under test
- cout  input  1  adder carry-out under test
- chk_valid  output  1  one-cycle pulse: a check completed
- chk_pass  output  1  result of that check; valid only with chk_valid
- pass_cnt, fail_cnt  output  CNT_W  saturating counts
- err  output  1  sticky: at least one mismatch since reset/clear
- fail_a, fail_b, fail_z  output  WIDTH  first failing transaction
- fail_cin, fail_cout  output  1  first failing transaction
- fail_exp  output  WIDTH+1  expected {cout, z} for first failure
- halted  output  1  state == HALT

## Operation
- Two-stage pipeline. S1 registers the accepted {a, b, cin, z, cout} plus a valid bit. S2 computes exp = a + b + cin in WIDTH+1 bits, zero-extending the operands. It compares exp against {cout, z} and registers the outcome.
- FSM states: RUN and HALT. Reset or clear goes to RUN.
  - RUN -> HALT when the S2 compare fails and HALT_ON_FAIL = 1.
  - HALT -> RUN only on clear or reset.
- in_ready = rst_n && !clear && (state == RUN). It is combinational from registered state.
- A transaction already in S1 when HALT is entered still drains. It is checked and counted normally.
- Counters increment by 1 per completed check and saturate at 2^CNT_W - 1. No wrap.
- First-fail capture registers load only when err == 0 and the check fails. They are held until reset/clear.
- Reset values: in_ready 0, chk_valid 0, chk_pass 0, both counters 0, err 0, all fail_* 0, halted 0, S1 valid 0.
- clear has priority over any in-flight transaction. The S1 valid bit is dropped, so no chk_valid results from it.
- Reset and clear asserted together behave as reset.
- Mid-operation reset flushes the pipeline. No chk_valid may appear after the reset edge for pre-reset transactions.

## Timing
- Transfer at rising edge N. Counters, err and fail_* update at edge N+1. chk_valid/chk_pass are high for the cycle following edge N+1.
- Latency is 2 edges. Throughput is one transaction per cycle with back-to-back in_valid.
- in_ready deasserts in the cycle after the failing check's edge N+1 when HALT_ON_FAIL = 1.
- in_ready reasserts the cycle after clear deasserts.
- halted mirrors state with no extra delay.

## Test plan
- a=0x00000005, b=0x00000003, cin=0, z=0x00000008, cout=0 -> chk_valid and chk_pass = 1 two edges after transfer; pass_cnt=1, fail_cnt=0, err=0.
- a=0xFFFFFFFF, b=0x00000001, cin=0, z=0x00000000, cout=1 -> pass. Repeat with cout=0 -> fail, err=1, fail_exp=0x1_00000000, fail_cout=0.
- HALT_ON_FAIL=1: a failing transaction, then a correct one back-to-back -> second is still counted (pass_cnt=1, fail_cnt=1), then in_ready=0 and halted=1. Pulsing clear -> counters 0, in_ready=1.
- CNT_W=4: 20 consecutive passing transactions -> pass_cnt=15, no wrap. A later failure -> fail_cnt=1.
- Reset mid-operation: assert rst_n=0 one cycle after a transfer -> no chk_valid; all outputs at reset values the cycle after.
- 1000 random vectors with z or cout bit-flips injected on 37 chosen indices -> fail_cnt=37, pass_cnt=963. fail_* equals the first injected vector with its true sum in fail_exp.

Source files
------------

// File: rtl/adder_result_checker.sv
// Response checker for the ripple adder: recomputes {cout, z} = a + b + cin,
// counts passes/fails, captures the first failure and can halt intake on it.
module adder_result_checker #(
  parameter int WIDTH        = 32,
  parameter int CNT_W        = 16,
  parameter int HALT_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] z,
  input  logic             cout,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_z,
  output logic             fail_cin,
  output logic             fail_cout,
  output logic [WIDTH:0]   fail_exp,
  output logic             halted
);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] z;
    logic             cout;
  } txn_t;

  state_t     state;
  txn_t       s1;
  logic [1:0] vld_pipe;  // [0] = S1 holds a txn, [1] = check result registered
  logic       xfer;
  logic [WIDTH:0] exp_sum;
  logic       s2_ok;

  assign in_ready  = rst_n && !clear && (state == RUN);
  assign xfer      = in_valid && in_ready;
  assign chk_valid = vld_pipe[1];
  assign halted    = (state == HALT);

  // Full WIDTH+1 compare so a wrong carry-out is always caught.
  assign exp_sum = {1'b0, s1.a} + {1'b0, s1.b} + {{WIDTH{1'b0}}, s1.cin};
  assign s2_ok   = (exp_sum == {s1.cout, s1.z});

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state     <= RUN;
      s1        <= '0;
      vld_pipe  <= '0;
      chk_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err       <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_z    <= '0;
      fail_cin  <= 1'b0;
      fail_cout <= 1'b0;
      fail_exp  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], xfer};
      if (xfer)
        s1 <= '{a: a, b: b, cin: cin, z: z, cout: cout};
      chk_pass <= vld_pipe[0] && s2_ok;
      if (vld_pipe[0]) begin
        if (s2_ok) begin
          pass_cnt <= pass_cnt + CNT_W'(pass_cnt != '1);
        end else begin
          fail_cnt <= fail_cnt + CNT_W'(fail_cnt != '1);
          err      <= 1'b1;
          if (!err) begin
            fail_a    <= s1.a;
            fail_b    <= s1.b;
            fail_z    <= s1.z;
            fail_cin  <= s1.cin;
            fail_cout <= s1.cout;
            fail_exp  <= exp_sum;
          end
          if (HALT_ON_FAIL != 0 && state == RUN)
            state <= HALT;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: default, halt-on-fail and 4-bit
// counter instances share one stimulus bus.
module tb_adder_result_checker;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n, clear, in_valid, cin, cout;
  logic [W-1:0] a, b, z;

  logic         d_rdy, d_cv, d_cp, d_err, d_fcin, d_fcout, d_halt;
  logic [15:0]  d_pc, d_fc;
  logic [W-1:0] d_fa, d_fb, d_fz;
  logic [W:0]   d_fe;

  logic         h_rdy, h_cv, h_cp, h_err, h_fcin, h_fcout, h_halt;
  logic [15:0]  h_pc, h_fc;
  logic [W-1:0] h_fa, h_fb, h_fz;
  logic [W:0]   h_fe;

  logic         c_rdy, c_cv, c_cp, c_err, c_fcin, c_fcout, c_halt;
  logic [3:0]   c_pc, c_fc;
  logic [W-1:0] c_fa, c_fb, c_fz;
  logic [W:0]   c_fe;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  adder_result_checker #(.WIDTH(W), .CNT_W(16), .HALT_ON_FAIL(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(d_rdy),
    .a(a), .b(b), .cin(cin), .z(z), .cout(cout),
    .chk_valid(d_cv), .chk_pass(d_cp), .pass_cnt(d_pc), .fail_cnt(d_fc), .err(d_err),
    .fail_a(d_fa), .fail_b(d_fb), .fail_z(d_fz), .fail_cin(d_fcin), .fail_cout(d_fcout),
    .fail_exp(d_fe), .halted(d_halt));

  adder_result_checker #(.WIDTH(W), .CNT_W(16), .HALT_ON_FAIL(1)) dut_h (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(h_rdy),
    .a(a), .b(b), .cin(cin), .z(z), .cout(cout),
    .chk_valid(h_cv), .chk_pass(h_cp), .pass_cnt(h_pc), .fail_cnt(h_fc), .err(h_err),
    .fail_a(h_fa), .fail_b(h_fb), .fail_z(h_fz), .fail_cin(h_fcin), .fail_cout(h_fcout),
    .fail_exp(h_fe), .halted(h_halt));

  adder_result_checker #(.WIDTH(W), .CNT_W(4), .HALT_ON_FAIL(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(c_rdy),
    .a(a), .b(b), .cin(cin), .z(z), .cout(cout),
    .chk_valid(c_cv), .chk_pass(c_cp), .pass_cnt(c_pc), .fail_cnt(c_fc), .err(c_err),
    .fail_a(c_fa), .fail_b(c_fb), .fail_z(c_fz), .fail_cin(c_fcin), .fail_cout(c_fcout),
    .fail_exp(c_fe), .halted(c_halt));

  task automatic apply_rst();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one transaction for one cycle, then wait for its result cycle.
  task automatic send(input logic [W-1:0] va, vb, input logic vcin,
                      input logic [W-1:0] vz, input logic vcout);
    @(negedge clk);
    a = va; b = vb; cin = vcin; z = vz; cout = vcout; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; z = '0; cout = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({d_rdy, d_cv, d_cp, d_err, d_halt, d_pc, d_fc} !== '0)
      $display("FAIL reset_outputs: got rdy=%b cv=%b cp=%b err=%b halt=%b pc=%0d fc=%0d, want all 0",
               d_rdy, d_cv, d_cp, d_err, d_halt, d_pc, d_fc);
    else passes++;
    checks++;
    if ({d_fa, d_fb, d_fz, d_fcin, d_fcout, d_fe} !== '0)
      $display("FAIL reset_fail_regs: got fa=%h fb=%h fz=%h fe=%h, want 0", d_fa, d_fb, d_fz, d_fe);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (d_rdy !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", d_rdy);
    else passes++;
  endtask

  task automatic test_basic();
    apply_rst();
    send(32'h5, 32'h3, 1'b0, 32'h8, 1'b0);
    checks++;
    if ({d_cv, d_cp} !== 2'b11 || d_pc !== 16'd1 || d_fc !== 16'd0 || d_err !== 1'b0)
      $display("FAIL basic_pass: got cv=%b cp=%b pc=%0d fc=%0d err=%b, want 1 1 1 0 0",
               d_cv, d_cp, d_pc, d_fc, d_err);
    else passes++;
    @(negedge clk);
    checks++;
    if (d_cv !== 1'b0) $display("FAIL basic_pulse_width: got cv=%b want 0", d_cv);
    else passes++;
  endtask

  task automatic test_carry();
    apply_rst();
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1);
    checks++;
    if ({d_cv, d_cp} !== 2'b11 || d_err !== 1'b0)
      $display("FAIL carry_pass: got cv=%b cp=%b err=%b, want 1 1 0", d_cv, d_cp, d_err);
    else passes++;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b0);
    checks++;
    if ({d_cv, d_cp} !== 2'b10 || d_err !== 1'b1 || d_pc !== 16'd1 || d_fc !== 16'd1)
      $display("FAIL carry_drop: got cv=%b cp=%b err=%b pc=%0d fc=%0d, want 1 0 1 1 1",
               d_cv, d_cp, d_err, d_pc, d_fc);
    else passes++;
    checks++;
    if (d_fe !== 33'h1_0000_0000 || d_fcout !== 1'b0 || d_fa !== 32'hFFFF_FFFF || d_fb !== 32'h1)
      $display("FAIL carry_capture: got fe=%h fcout=%b fa=%h fb=%h, want 100000000 0 ffffffff 1",
               d_fe, d_fcout, d_fa, d_fb);
    else passes++;
  endtask

  task automatic test_halt();
    apply_rst();
    @(negedge clk);
    a = 32'd10; b = 32'd20; cin = 1'b1; z = 32'd30; cout = 1'b0; in_valid = 1'b1;  // bad: 31
    @(negedge clk);
    a = 32'd1; b = 32'd2; cin = 1'b0; z = 32'd3; cout = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (h_halt !== 1'b1 || h_rdy !== 1'b0)
      $display("FAIL halt_enter: got halted=%b rdy=%b, want 1 0", h_halt, h_rdy);
    else passes++;
    @(negedge clk);
    checks++;
    if (h_pc !== 16'd1 || h_fc !== 16'd1 || h_fz !== 32'd30 || h_fe !== 33'd31)
      $display("FAIL halt_drain: got pc=%0d fc=%0d fz=%0d fe=%0d, want 1 1 30 31", h_pc, h_fc, h_fz, h_fe);
    else passes++;
    send(32'd4, 32'd4, 1'b0, 32'd8, 1'b0);
    @(negedge clk);
    checks++;
    if (h_pc !== 16'd1 || h_halt !== 1'b1 || d_halt !== 1'b0)
      $display("FAIL halt_blocks: got h_pc=%0d h_halt=%b d_halt=%b, want 1 1 0", h_pc, h_halt, d_halt);
    else passes++;
    clear = 1'b1;
    @(negedge clk);
    checks++;
    if (h_rdy !== 1'b0) $display("FAIL halt_clear_rdy: got %b want 0", h_rdy);
    else passes++;
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (h_pc !== 16'd0 || h_fc !== 16'd0 || h_rdy !== 1'b1 || h_halt !== 1'b0 || h_err !== 1'b0 || h_fa !== '0)
      $display("FAIL halt_clear: got pc=%0d fc=%0d rdy=%b halt=%b err=%b fa=%h, want 0 0 1 0 0 0",
               h_pc, h_fc, h_rdy, h_halt, h_err, h_fa);
    else passes++;
  endtask

  task automatic test_saturate();
    apply_rst();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = 32'(i); b = 32'(2 * i); cin = 1'b0; z = 32'(3 * i); cout = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (c_pc !== 4'd15 || d_pc !== 16'd20 || c_fc !== 4'd0)
      $display("FAIL sat_pass: got c_pc=%0d d_pc=%0d c_fc=%0d, want 15 20 0", c_pc, d_pc, c_fc);
    else passes++;
    send(32'd7, 32'd7, 1'b1, 32'd14, 1'b0);
    checks++;
    if (c_fc !== 4'd1 || c_pc !== 4'd15)
      $display("FAIL sat_fail: got c_fc=%0d c_pc=%0d, want 1 15", c_fc, c_pc);
    else passes++;
  endtask

  task automatic test_mid_reset();
    apply_rst();
    @(negedge clk);
    a = 32'd9; b = 32'd9; cin = 1'b0; z = 32'd0; cout = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (d_cv !== 1'b0 || d_fc !== 16'd0 || d_err !== 1'b0 || d_fa !== '0 || d_rdy !== 1'b0)
      $display("FAIL midrst_flush: got cv=%b fc=%0d err=%b fa=%h rdy=%b, want 0 0 0 0 0",
               d_cv, d_fc, d_err, d_fa, d_rdy);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (d_cv !== 1'b0 || d_rdy !== 1'b1 || d_fc !== 16'd0)
      $display("FAIL midrst_after: got cv=%b rdy=%b fc=%0d, want 0 1 0", d_cv, d_rdy, d_fc);
    else passes++;
  endtask

  task automatic test_clear_flush();
    apply_rst();
    @(negedge clk);
    a = 32'd2; b = 32'd2; cin = 1'b0; z = 32'd5; cout = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (d_cv !== 1'b0 || d_fc !== 16'd0 || d_err !== 1'b0)
      $display("FAIL clear_flush: got cv=%b fc=%0d err=%b, want 0 0 0", d_cv, d_fc, d_err);
    else passes++;
    @(negedge clk);
    checks++;
    if (d_cv !== 1'b0 || d_fc !== 16'd0)
      $display("FAIL clear_flush_late: got cv=%b fc=%0d, want 0 0", d_cv, d_fc);
    else passes++;
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, rz, fa, fb, fz;
    logic         rcin, rcout, fcin, fcout;
    logic [W:0]   sum, fexp;
    int           k, nflip;
    logic         first;
    fa = '0; fb = '0; fz = '0; fcin = 1'b0; fcout = 1'b0; fexp = '0;
    first = 1'b1; nflip = 0;
    apply_rst();
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rcin = 1'($urandom_range(1));
      sum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
      rz = sum[W-1:0]; rcout = sum[W];
      if (i % 27 == 5) begin
        k = i / 27;
        if (k % 2 == 0) rz[k % 32] = ~rz[k % 32];
        else            rcout = ~rcout;
        nflip++;
        if (first) begin
          fa = ra; fb = rb; fz = rz; fcin = rcin; fcout = rcout; fexp = sum; first = 1'b0;
        end
      end
      @(negedge clk);
      a = ra; b = rb; cin = rcin; z = rz; cout = rcout; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (d_fc !== 16'(nflip) || d_pc !== 16'(1000 - nflip) || nflip != 37)
      $display("FAIL rand_counts: got pc=%0d fc=%0d, want 963 37 (injected %0d)", d_pc, d_fc, nflip);
    else passes++;
    checks++;
    if (d_fa !== fa || d_fb !== fb || d_fz !== fz || d_fcin !== fcin || d_fcout !== fcout || d_fe !== fexp)
      $display("FAIL rand_capture: got a=%h b=%h z=%h cin=%b cout=%b exp=%h, want %h %h %h %b %b %h",
               d_fa, d_fb, d_fz, d_fcin, d_fcout, d_fe, fa, fb, fz, fcin, fcout, fexp);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_halt();
    test_saturate();
    test_mid_reset();
    test_clear_flush();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
